filter_out_packetizer: RTL and testbench
========================================

FILTER_OUT_PACKETIZER -- requirements
Module: filter_out_packetizer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning buffer depth in samples (power of 2, at least 4).
REQ-002 SHALL have parameter PKT_LEN, default 32, meaning output transfers per packet (at least 2).
REQ-003 SHALL have port clk, input, 1, the system clock; reset srst, synchronous, active-high; clock clk.
REQ-004 SHALL have port srst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port s_tdata, input, 14, signed two's-complement filter output sample.
REQ-006 SHALL have port s_tvalid, input, 1, sample strobe; there is no backpressure toward the filter.
REQ-007 SHALL have port s_mode, input, 1, filter ctrl value aligned with s_tvalid (0 = differentiator, 1 = integrator).
REQ-008 SHALL have port m_tdata, output, 16, s_tdata sign-extended to 16 bits.
REQ-009 SHALL have port m_tvalid, output, 1, AXI-Stream valid.
REQ-010 SHALL have port m_tready, input, 1, AXI-Stream ready.
REQ-011 SHALL have port m_tlast, output, 1, marks the last transfer of a packet.
REQ-012 SHALL have port m_tuser, output, 1, s_mode captured with the sample.
REQ-013 SHALL have port ovf_clr, input, 1, single-cycle clear of the overflow status.
REQ-014 SHALL have port overflow, output, 1, sticky flag meaning one or more samples were dropped.
REQ-015 SHALL have port drop_cnt, output, 16, count of dropped samples; saturates at 0xFFFF.
REQ-016 SHALL have port fill_level, output, clog2(FIFO_DEPTH)+1, current number of stored entries.

Function
REQ-017 SHALL write {s_mode, s_tdata} into the FIFO on every cycle where s_tvalid=1 and fill_level<FIFO_DEPTH.
REQ-018 SHALL judge "full" on the pre-cycle count: when fill_level==FIFO_DEPTH, the write is dropped even if a read happens in the same cycle.
REQ-019 SHALL, on a dropped write, set overflow=1 and increment drop_cnt by 1 with saturation, one cycle later.
REQ-020 SHALL, when ovf_clr=1, clear overflow and drop_cnt; if a drop occurs in the same cycle, overflow=1 and drop_cnt=1.
REQ-021 SHALL operate as first-word-fall-through: m_tvalid=1 whenever fill_level>0, and m_tdata/m_tuser present the oldest entry.
REQ-022 SHALL have latency of 1 cycle from a write into an empty FIFO to m_tvalid=1.
REQ-023 SHALL treat m_tvalid&&m_tready as a transfer; data, user and last SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-024 SHALL, on a simultaneous accepted write and transfer, leave fill_level unchanged.
REQ-025 SHALL wrap read and write pointers modulo FIFO_DEPTH without loss or duplication.
REQ-026 SHALL keep a packet counter 0..PKT_LEN-1 that increments per transfer and wraps to 0 after PKT_LEN-1.
REQ-027 SHALL drive m_tlast = m_tvalid && (packet counter == PKT_LEN-1).
REQ-028 SHALL NOT shorten or realign packets when samples are dropped or when s_mode changes; m_tuser SHALL carry the mode for each sample.
REQ-029 SHALL leave the packet counter unchanged while no transfer occurs, including when the FIFO is empty.

Reset
REQ-030 SHALL, while srst=1, set m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser=0, overflow=0, drop_cnt=0, fill_level=0, pointers=0 and packet counter=0.
REQ-031 SHALL, when srst is asserted mid-packet or mid-burst, discard all stored entries; the first transfer after reset SHALL start a new packet.
REQ-032 SHALL ignore s_tvalid during any cycle in which srst=1.

Structure
REQ-033 SHALL have OUT_WL=16 and the default FIFO_DEPTH and PKT_LEN values placed in adaptive_filter_pkg next to WORDLENGTH.
REQ-034 SHALL implement storage as sub-module sync_fifo (width 15, depth FIFO_DEPTH, FWFT, with count output); the packet counter and overflow logic SHALL live in the top level.

Verification
REQ-035 SHALL verify simple flow: with m_tready=1, input 0x1FFF then 0x2000 -> m_tdata 0x1FFF then 0xE000, each 1 cycle after input, overflow=0.
REQ-036 SHALL verify overflow: with m_tready=0, 20 consecutive samples at FIFO_DEPTH=16 -> fill_level=16, overflow=1, drop_cnt=4; draining then outputs samples 1..16 in order.
REQ-037 SHALL verify full plus read: at fill_level=16, s_tvalid=1 and a transfer in the same cycle -> write dropped, drop_cnt+1, fill_level=15.
REQ-038 SHALL verify packetization: 70 samples with random m_tready at PKT_LEN=32 -> m_tlast on transfers 32 and 64 only; data stable whenever stalled.
REQ-039 SHALL verify mode tag: s_mode toggles 0->1 at sample 10 -> m_tuser=1 from transfer 10 onward, with no extra m_tlast.
REQ-040 SHALL verify reset mid-packet and overflow clear: srst after 5 transfers with 3 entries stored -> m_tvalid=0 next cycle, and the next packet's m_tlast falls on transfer 32; ovf_clr pulse -> overflow=0, drop_cnt=0.

Source files
------------

// File: rtl/adaptive_filter_pkg.sv
// Shared constants and types for the adaptive filter datapath.
//   WORDLENGTH         : filter sample width (signed)
//   OUT_WL             : AXI-Stream output word width
//   FIFO_DEPTH_DEFAULT : default output buffer depth, in samples
//   PKT_LEN_DEFAULT    : default number of transfers per output packet
package adaptive_filter_pkg;

    localparam int unsigned WORDLENGTH         = 14;
    localparam int unsigned OUT_WL             = 16;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 16;
    localparam int unsigned PKT_LEN_DEFAULT    = 32;

    // One buffered sample: mode tag alongside the raw sample.
    typedef struct packed {
        logic                         mode;
        logic signed [WORDLENGTH-1:0] data;
    } pkt_entry_t;

    localparam int unsigned ENTRY_W = $bits(pkt_entry_t);

    function automatic logic [OUT_WL-1:0] sign_extend(input logic [WORDLENGTH-1:0] d);
        return {{(OUT_WL - WORDLENGTH){d[WORDLENGTH-1]}}, d};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
//   clk, srst   : clock, synchronous active-high reset (clears pointers/count)
//   wr_en_i     : write request; accepted only when count_o < DEPTH
//   wr_data_i   : write data
//   rd_en_i     : read/pop request; honoured only when count_o > 0
//   rd_data_o   : oldest entry (zero when empty)
//   full_o      : count_o == DEPTH
//   count_o     : number of stored entries
module sync_fifo #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             wr_ok, rd_ok;

    // Full is judged on the pre-cycle count, so a same-cycle pop does not make room.
    assign wr_ok = wr_en_i && (count_q != FULL_CNT);
    assign rd_ok = rd_en_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + ONE_PTR;
        if (rd_ok) rd_ptr_d = rd_ptr_q + ONE_PTR;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst && wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign full_o    = (count_q == FULL_CNT);
    assign count_o   = count_q;

endmodule

// File: rtl/filter_out_packetizer.sv
// Buffers filter output samples and emits them as fixed-length AXI-Stream packets.
//   clk, srst   : clock, synchronous active-high reset
//   s_tdata     : signed filter sample, s_tvalid strobe (no backpressure), s_mode tag
//   m_tdata     : sign-extended sample; m_tvalid/m_tready/m_tlast AXI-Stream handshake
//   m_tuser     : mode captured with the sample
//   ovf_clr     : single-cycle clear of overflow status
//   overflow    : sticky dropped-sample flag; drop_cnt: saturating drop count
//   fill_level  : current number of buffered samples
module filter_out_packetizer
    import adaptive_filter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned PKT_LEN    = PKT_LEN_DEFAULT
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [WORDLENGTH-1:0]       s_tdata,
    input  logic                        s_tvalid,
    input  logic                        s_mode,
    output logic [OUT_WL-1:0]           m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        m_tlast,
    output logic                        m_tuser,
    input  logic                        ovf_clr,
    output logic                        overflow,
    output logic [15:0]                 drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fill_level
);

    localparam int unsigned PW       = $clog2(PKT_LEN);
    localparam logic [PW-1:0] PKT_LAST = PW'(PKT_LEN - 1);
    localparam logic [PW-1:0] PKT_ONE  = PW'(1);

    pkt_entry_t wr_entry, rd_entry;
    logic       wr_en, full, drop, xfer;
    logic       has_data;

    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    assign wr_entry = '{mode: s_mode, data: s_tdata};
    assign wr_en    = s_tvalid && !srst;
    assign drop     = wr_en && full;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (srst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_entry),
        .rd_en_i   (xfer),
        .rd_data_o (rd_entry),
        .full_o    (full),
        .count_o   (fill_level)
    );

    // Outputs are held at zero during reset even before the FIFO state clears.
    assign has_data = (fill_level != '0);
    assign m_tvalid = has_data && !srst;
    assign xfer     = m_tvalid && m_tready;
    assign m_tdata  = m_tvalid ? sign_extend(rd_entry.data) : '0;
    assign m_tuser  = m_tvalid && rd_entry.mode;
    assign m_tlast  = m_tvalid && (pkt_cnt_q == PKT_LAST);

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (xfer) pkt_cnt_d = (pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + PKT_ONE;

        // A drop in the clear cycle wins: the flag stays set and the count restarts at 1.
        if (ovf_clr) begin
            overflow_d = drop;
            drop_cnt_d = drop ? 16'd1 : '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pkt_cnt_q  <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_filter_out_packetizer.sv
module tb_filter_out_packetizer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned PLEN  = 32;
    localparam int unsigned FW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          srst;
    logic [13:0]   s_tdata;
    logic          s_tvalid;
    logic          s_mode;
    logic [15:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          m_tuser;
    logic          ovf_clr;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic [FW-1:0] fill_level;

    filter_out_packetizer #(
        .FIFO_DEPTH (DEPTH),
        .PKT_LEN    (PLEN)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_mode     (s_mode),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] sx(input logic [13:0] d);
        return {{2{d[13]}}, d};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk);
        srst = 1'b1; s_tvalid = 1'b1; s_tdata = 14'h0AA; s_mode = 1'b1;
        m_tready = 1'b1; ovf_clr = 1'b0;
        step();
        @(negedge clk);
        if (chk) begin
            check("rst_valid", {31'd0, m_tvalid}, 32'd0);
            check("rst_last",  {31'd0, m_tlast},  32'd0);
            check("rst_data",  {16'd0, m_tdata},  32'd0);
            check("rst_user",  {31'd0, m_tuser},  32'd0);
            check("rst_ovf",   {31'd0, overflow}, 32'd0);
            check("rst_drop",  {16'd0, drop_cnt}, 32'd0);
            check("rst_fill",  32'(fill_level),   32'd0);
        end
        step();
        srst = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_mode = 1'b0; m_tready = 1'b0;
    endtask

    typedef struct packed {
        logic [13:0]   d;
        logic          v;
        logic          mode;
        logic          rdy;
        logic          e_valid;
        logic [15:0]   e_data;
        logic          e_user;
        logic          e_last;
        logic [FW-1:0] e_fill;
    } vec_t;

    vec_t tbl [12];

    initial begin
        pkt_entry_q_init();
    end

    function automatic void pkt_entry_q_init();
    endfunction

    initial begin
        logic [14:0] q [$];
        int sent, xfers, pkt, lasts, cyc, xn;
        bit exp_v;

        srst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_mode = 1'b0;
        m_tready = 1'b0; ovf_clr = 1'b0;

        // -------- table: simple flow, sign extension, mode tag, stall stability
        tbl[0]  = '{14'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0};
        tbl[1]  = '{14'h1FFF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0};
        tbl[2]  = '{14'h2000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1FFF, 1'b0, 1'b0, 5'd1};
        tbl[3]  = '{14'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hE000, 1'b0, 1'b0, 5'd1};
        tbl[4]  = '{14'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0};
        tbl[5]  = '{14'h0005, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0};
        tbl[6]  = '{14'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 5'd1};
        tbl[7]  = '{14'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 5'd1};
        tbl[8]  = '{14'h3FFF, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 5'd1};
        tbl[9]  = '{14'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 5'd1};
        tbl[10] = '{14'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 5'd1};
        tbl[11] = '{14'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0};

        do_reset(1'b1);

        for (int i = 0; i < 12; i++) begin
            s_tdata = tbl[i].d; s_tvalid = tbl[i].v; s_mode = tbl[i].mode; m_tready = tbl[i].rdy;
            @(negedge clk);
            if ({m_tvalid, m_tdata, m_tuser, m_tlast, fill_level, overflow} !==
                {tbl[i].e_valid, tbl[i].e_data, tbl[i].e_user, tbl[i].e_last, tbl[i].e_fill, 1'b0}) begin
                n_chk++;
                $display("FAIL vec%0d: got v=%0b d=0x%0h u=%0b l=%0b f=%0d o=%0b, expected v=%0b d=0x%0h u=%0b l=%0b f=%0d o=0",
                         i, m_tvalid, m_tdata, m_tuser, m_tlast, fill_level, overflow,
                         tbl[i].e_valid, tbl[i].e_data, tbl[i].e_user, tbl[i].e_last, tbl[i].e_fill);
            end else begin
                n_chk++;
                n_pass++;
            end
            step();
        end
        s_tvalid = 1'b0;

        // -------- overflow: 20 samples into a stalled 16-deep buffer
        do_reset(1'b0);
        m_tready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            s_tvalid = 1'b1; s_tdata = 14'(i); s_mode = 1'b0;
            @(negedge clk);
            if (i == 17) begin
                check("fill_at_full",    32'(fill_level),   32'd16);
                check("ovf_before_drop", {31'd0, overflow}, 32'd0);
            end
            if (i == 18) begin
                check("ovf_after_drop",  {31'd0, overflow}, 32'd1);
                check("drop_after_1",    {16'd0, drop_cnt}, 32'd1);
            end
            step();
        end
        s_tvalid = 1'b0;
        @(negedge clk);
        check("ovf_fill",  32'(fill_level),   32'd16);
        check("ovf_flag",  {31'd0, overflow}, 32'd1);
        check("ovf_drops", {16'd0, drop_cnt}, 32'd4);
        check("ovf_head",  {16'd0, m_tdata},  32'd1);
        step();

        // full plus read in the same cycle: write still dropped
        s_tvalid = 1'b1; s_tdata = 14'd99; m_tready = 1'b1;
        @(negedge clk);
        check("fr_head", {16'd0, m_tdata}, 32'd1);
        step();
        s_tvalid = 1'b0; m_tready = 1'b0;
        @(negedge clk);
        check("fr_fill", 32'(fill_level),   32'd15);
        check("fr_drop", {16'd0, drop_cnt}, 32'd5);
        step();

        m_tready = 1'b1;
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("drain_%0d", k), {16'd0, m_tdata}, 32'(k));
            step();
        end
        @(negedge clk);
        check("drain_empty", {31'd0, m_tvalid}, 32'd0);
        step();

        // overflow clear
        m_tready = 1'b0; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        check("clr_ovf",  {31'd0, overflow}, 32'd0);
        check("clr_drop", {16'd0, drop_cnt}, 32'd0);
        step();

        // clear coinciding with a drop
        for (int i = 0; i < 18; i++) begin
            s_tvalid = 1'b1; s_tdata = 14'(200 + i);
            step();
        end
        ovf_clr = 1'b1;
        step();
        s_tvalid = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        check("clrdrop_ovf",  {31'd0, overflow}, 32'd1);
        check("clrdrop_drop", {16'd0, drop_cnt}, 32'd1);
        check("clrdrop_fill", 32'(fill_level),   32'd16);
        step();

        // -------- reset from a dirty state, then reset mid-packet
        do_reset(1'b1);
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_tvalid = 1'b1; s_tdata = 14'(100 + i);
            step();
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        m_tready = 1'b0;
        @(negedge clk);
        check("mid_fill", 32'(fill_level), 32'd3);
        step();
        srst = 1'b1; s_tvalid = 1'b1; s_tdata = 14'd555;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, m_tvalid}, 32'd0);
        step();
        srst = 1'b0; s_tvalid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {31'd0, m_tvalid}, 32'd0);
        check("post_rst_fill",  32'(fill_level),   32'd0);
        step();

        m_tready = 1'b1;
        xn = 0;
        for (int c = 0; c < 42; c++) begin
            s_tvalid = (c < 40); s_tdata = 14'(c + 1);
            @(negedge clk);
            if (m_tvalid) begin
                xn++;
                check($sformatf("pr_data_%0d", xn), {16'd0, m_tdata}, 32'(xn));
                check($sformatf("pr_last_%0d", xn), {31'd0, m_tlast}, {31'd0, (xn == 32)});
            end
            step();
        end
        s_tvalid = 1'b0;
        check("pr_xfers", 32'(xn), 32'd40);

        // -------- packetization with random ready, mode switches at sample 10
        do_reset(1'b0);
        sent = 0; xfers = 0; pkt = 0; lasts = 0; cyc = 0;
        while (xfers < 70 && cyc < 3000) begin
            cyc++;
            s_tvalid = (sent < 70) && (q.size() < DEPTH);
            s_mode   = (sent >= 9);
            s_tdata  = 14'(sent + 1);
            m_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_v = (q.size() > 0);
            check("pk_valid", {31'd0, m_tvalid}, {31'd0, exp_v});
            check("pk_fill",  32'(fill_level),   32'(q.size()));
            if (exp_v) begin
                check("pk_data", {16'd0, m_tdata}, {16'd0, sx(q[0][13:0])});
                check("pk_user", {31'd0, m_tuser}, {31'd0, q[0][14]});
                check("pk_last", {31'd0, m_tlast}, {31'd0, (pkt == PLEN - 1)});
                if (m_tready) begin
                    xfers++;
                    if (m_tlast) lasts++;
                    pkt = (pkt + 1) % PLEN;
                    void'(q.pop_front());
                end
            end
            if (s_tvalid) begin
                q.push_back({s_mode, s_tdata});
                sent++;
            end
            step();
        end
        s_tvalid = 1'b0;
        check("pk_xfers", 32'(xfers), 32'd70);
        check("pk_lasts", 32'(lasts), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
